// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: start/ready request channel plus done/product result channel
// for the sequential multiplier. The master drives operands; the slave returns results.
`timescale 1ns/1ps
interface seq_mult_param_if #(
  parameter int N = 8
);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  ready, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output ready, done, product
  );
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param: N-bit shift-add multiplier (unsigned or signed per operation).
// Operand magnitudes are multiplied unsigned and the sign is restored in FIX.
// Optional macro EARLY_TERM_EN: skip trailing all-zero multiplier bits with a
// single multi-bit shift, giving data-dependent latency with identical results.
`timescale 1ns/1ps
module seq_mult_param #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  seq_mult_param_if.slave  bus
);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_FIX} state_t;

  state_t           state_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     q_q;
  logic [N-1:0]     m_q;
  logic             c_q;
  logic [CNT_W-1:0] p_q;
  logic             sign_q;
  logic             done_q;
  logic [2*N-1:0]   product_q;

  logic [N-1:0]     a_abs_d;
  logic [N-1:0]     b_abs_d;
  logic [N:0]       sum_d;
  logic [2*N:0]     shr_d;
  logic [2*N-1:0]   aq_d;
  logic [2*N-1:0]   fix_d;

  // Operand magnitudes, partial-sum adder, single-step shift and sign fix-up
  always_comb begin
    a_abs_d = (bus.signed_mode & bus.a[N-1]) ? ('0 - bus.a) : bus.a;
    b_abs_d = (bus.signed_mode & bus.b[N-1]) ? ('0 - bus.b) : bus.b;
    sum_d   = {1'b0, a_q} + {1'b0, m_q};
    shr_d   = {1'b0, c_q, a_q, q_q[N-1:1]};
    aq_d    = {a_q, q_q};
    fix_d   = sign_q ? ('0 - aq_d) : aq_d;
  end

`ifdef EARLY_TERM_EN
  logic [N-1:0] rem_mask_d;
  logic         et_hit_d;
  logic [2*N:0] far_d;

  // Unprocessed multiplier bits are Q[P:1]; if all zero, the remaining P+1
  // one-bit shifts collapse into a single shift with no further adds.
  always_comb begin
    rem_mask_d = (N'(1) << p_q) - N'(1);
    et_hit_d   = (p_q != '0) && ((q_q[N-1:1] & rem_mask_d[N-2:0]) == '0);
    far_d      = {c_q, a_q, q_q} >> (p_q + CNT_W'(1));
  end
`endif

  // Controller and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      c_q       <= 1'b0;
      p_q       <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            m_q     <= a_abs_d;
            q_q     <= b_abs_d;
            a_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= CNT_W'(N);
            sign_q  <= bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (q_q[0]) {c_q, a_q} <= sum_d;
          p_q     <= p_q - CNT_W'(1);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
`ifdef EARLY_TERM_EN
          if (et_hit_d) begin
            {c_q, a_q, q_q} <= far_d;
            state_q         <= S_FIX;
          end else begin
            {c_q, a_q, q_q} <= shr_d;
            state_q         <= (p_q == '0) ? S_FIX : S_ADD;
          end
`else
          {c_q, a_q, q_q} <= shr_d;
          state_q         <= (p_q == '0) ? S_FIX : S_ADD;
`endif
        end
        S_FIX: begin
          product_q <= fix_d;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: table-driven checks plus back-to-back and reset sequences
// for seq_mult_param (N=8). Honours EARLY_TERM_EN for expected latencies.
`timescale 1ns/1ps
module tb_seq_mult_param;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult_param_if #(.N(N)) bus ();

  seq_mult_param #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] prod;
  } vec_t;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } sb_t;

  vec_t vecs[10];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mul_model(input logic [7:0] x, input logic [7:0] y, input logic sm);
    longint sx, sy;
    sx = sm ? longint'({{56{x[7]}}, x}) : longint'({56'b0, x});
    sy = sm ? longint'({{56{y[7]}}, y}) : longint'({56'b0, y});
    return 16'(sx * sy);
  endfunction

  // Cycles from the accept cycle (index 0) to the done cycle
  function automatic int exp_lat(input logic [7:0] y, input logic sm);
`ifdef EARLY_TERM_EN
    logic [7:0] m;
    int k;
    m = (sm && y[7]) ? (8'd0 - y) : y;
    k = 1;
    for (int i = 0; i < N; i++) if (m[i]) k = i + 1;
    return 2 * k + 2;
`else
    return 2 * N + 2;
`endif
  endfunction

  task automatic pop_and_check(input int cnt);
    sb_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("latency", 32'(cnt), 32'(e.lat));
      check("product", 32'(bus.product), 32'(e.prod));
    end
  endtask

  // Called #1 after a posedge while idle
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsm,
                        input logic [15:0] tp);
    int   cnt;
    sb_t  e;
    check("ready_idle", 32'(bus.ready), 32'd1);
    bus.a = ta; bus.b = tb_v; bus.signed_mode = tsm; bus.start = 1'b1;
    e.prod = tp; e.lat = exp_lat(tb_v, tsm);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.signed_mode = 1'($urandom);
    cnt = 1;
    check("ready_busy", 32'(bus.ready), 32'd0);
    while (!bus.done && cnt < 200) begin
      if (cnt == 5) bus.start = 1'b1;
      if (cnt == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(bus.done), 32'd1);
    check("ready_in_done", 32'(bus.ready), 32'd1);
    pop_and_check(cnt);
    @(posedge clk); #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("product_hold", 32'(bus.product), 32'(tp));
    repeat (2) @(posedge clk);
    #1;
    check("product_hold2", 32'(bus.product), 32'(tp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   idx;
    int   results;
    sb_t  e;
    vec_t ops[5];

    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
    vecs[1] = '{8'hFD,  8'd7,   1'b1, 16'hFFEB};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[4] = '{8'd3,   8'd1,   1'b0, 16'h0003};
    vecs[5] = '{8'd3,   8'd0,   1'b0, 16'h0000};
    vecs[6] = '{8'd3,   8'h80,  1'b0, 16'h0180};
    vecs[7] = '{8'h80,  8'hFF,  1'b1, 16'h0080};
    vecs[8] = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    vecs[9] = '{8'd5,   8'hFE,  1'b1, 16'hFFF6};

    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].prod);

    // Reset in the middle of 13*11
    bus.a = 8'd13; bus.b = 8'd11; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_product", 32'(bus.product), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_product", 32'(bus.product), 32'd0);
    run_op(8'd13, 8'd11, 1'b0, 16'h008F);

    // Back-to-back with start held high; new operands presented in each done cycle
    for (int i = 0; i < 5; i++) begin
      ops[i].a  = 8'($urandom);
      ops[i].b  = (i == 0) ? 8'h80 : 8'($urandom);
      ops[i].sm = 1'($urandom);
      ops[i].prod = mul_model(ops[i].a, ops[i].b, ops[i].sm);
    end
    bus.a = ops[0].a; bus.b = ops[0].b; bus.signed_mode = ops[0].sm; bus.start = 1'b1;
    e.prod = ops[0].prod; e.lat = exp_lat(ops[0].b, ops[0].sm);
    sb.push_back(e);
    idx = 1; results = 0; cnt = 0;
    for (int t = 0; t < 400 && results < 5; t++) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        check("b2b_ready_busy", 32'(bus.ready), 32'd0);
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.signed_mode = 1'($urandom);
      end
      if (bus.done) begin
        results++;
        pop_and_check(cnt);
        cnt = 0;
        if (idx < 5) begin
          bus.a = ops[idx].a; bus.b = ops[idx].b; bus.signed_mode = ops[idx].sm;
          e.prod = ops[idx].prod; e.lat = exp_lat(ops[idx].b, ops[idx].sm);
          sb.push_back(e);
          idx++;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_results", 32'(results), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
